// File: rtl/carfield_island_boot_seq.sv
// carfield_island_boot_seq
//
// Boot and power-sequencing controller for the Carfield accelerator islands
// (index 0 = safety island, 1 = integer cluster). Each island runs its own
// OFF -> WAIT_GNT -> RST -> SETTLE -> RUN -> DONE sequence. A single shared
// round-robin slot ensures only one island is inside its reset-release window
// (RST + SETTLE) at any time, which bounds inrush current.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             per-island start request (level-sampled)
//   stop_i              per-island stop / power-down request
//   boot_addr_i         per-island boot address, captured when start is accepted
//   eoc_i               per-island end-of-computation level
//   isl_rst_o           island reset (active-high)
//   isl_clk_en_o        island clock gate enable
//   isl_fetch_en_o      island core fetch enable
//   isl_boot_addr_o     island boot address
//   done_irq_o          one-cycle completion pulse
//   err_o               sticky RUN timeout error
//   busy_o              shared reset-release slot is held
//
// Optional feature: define CARFIELD_BOOT_TIMEOUT_EN to add a per-island RUN
// watchdog that moves the island to ERR after TimeoutCycles without eoc_i.
// Without it, ERR is unreachable and err_o is tied low.
module carfield_island_boot_seq #(
    parameter int unsigned          NumIslands      = 2,
    parameter int unsigned          AddrWidth       = 32,
    parameter int unsigned          RstCycles       = 16,
    parameter int unsigned          SettleCycles    = 4,
    parameter int unsigned          TimeoutCycles   = 1024,
    parameter logic [AddrWidth-1:0] DefaultBootAddr = AddrWidth'(32'h7800_0000)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumIslands-1:0]                 start_i,
    input  logic [NumIslands-1:0]                 stop_i,
    input  logic [NumIslands-1:0][AddrWidth-1:0]  boot_addr_i,
    input  logic [NumIslands-1:0]                 eoc_i,
    output logic [NumIslands-1:0]                 isl_rst_o,
    output logic [NumIslands-1:0]                 isl_clk_en_o,
    output logic [NumIslands-1:0]                 isl_fetch_en_o,
    output logic [NumIslands-1:0][AddrWidth-1:0]  isl_boot_addr_o,
    output logic [NumIslands-1:0]                 done_irq_o,
    output logic [NumIslands-1:0]                 err_o,
    output logic                                  busy_o
);

    localparam int unsigned MaxCycles = (RstCycles > SettleCycles) ? RstCycles : SettleCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam int unsigned IdxW      = (NumIslands > 1) ? $clog2(NumIslands) : 1;

    typedef enum logic [2:0] {
        StOff, StWaitGnt, StRst, StSettle, StRun, StDone, StErr
    } state_e;

    state_e                                 state_q [NumIslands];
    state_e                                 state_d [NumIslands];
    logic [CntW-1:0]                        cnt_q   [NumIslands];
    logic [CntW-1:0]                        cnt_d   [NumIslands];
    logic [NumIslands-1:0][AddrWidth-1:0]   addr_q, addr_d;
    logic [NumIslands-1:0]                  done_q, done_d;
    logic                                   slot_held_q, slot_held_d;
    logic [IdxW-1:0]                        holder_q, holder_d;
    logic [IdxW-1:0]                        rr_q, rr_d;

    logic                                   settle_rel;
    logic                                   slot_free;
    logic                                   gnt_valid;
    logic [IdxW-1:0]                        gnt_idx;
    logic [NumIslands-1:0]                  gnt;
    int unsigned                            cand;
    logic [IdxW-1:0]                        cand_idx;

`ifdef CARFIELD_BOOT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0] tcnt_q [NumIslands];
    logic [TW-1:0] tcnt_d [NumIslands];
`endif

    // Arbiter. The holder's last SETTLE cycle frees the slot combinationally
    // so the next island can be granted with no idle gap. A stop releases the
    // slot only through the register, one cycle later.
    always_comb begin
        settle_rel = slot_held_q && (state_q[holder_q] == StSettle) &&
                     (cnt_q[holder_q] == CntW'(1));
        slot_free  = !slot_held_q || settle_rel;
        gnt_valid  = 1'b0;
        gnt_idx    = '0;
        gnt        = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned off = 0; off < NumIslands; off++) begin
            cand = 32'(rr_q) + off;
            if (cand >= NumIslands) cand = cand - NumIslands;
            cand_idx = IdxW'(cand);
            if (!gnt_valid && slot_free && (state_q[cand_idx] == StWaitGnt) &&
                !stop_i[cand_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
        if (gnt_valid) gnt[gnt_idx] = 1'b1;

        slot_held_d = slot_held_q;
        holder_d    = holder_q;
        rr_d        = rr_q;
        if (slot_held_q && (settle_rel || stop_i[holder_q])) slot_held_d = 1'b0;
        if (gnt_valid) begin
            slot_held_d = 1'b1;
            holder_d    = gnt_idx;
            rr_d        = (gnt_idx == IdxW'(NumIslands - 1)) ? '0 : gnt_idx + IdxW'(1);
        end
    end

    // Per-island sequencing; stop has priority over every other event.
    always_comb begin
        for (int i = 0; i < NumIslands; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            addr_d[i]  = addr_q[i];
            done_d[i]  = 1'b0;
`ifdef CARFIELD_BOOT_TIMEOUT_EN
            tcnt_d[i]  = tcnt_q[i];
`endif
            if (stop_i[i]) begin
                state_d[i] = StOff;
            end else begin
                unique case (state_q[i])
                    StOff, StDone, StErr: begin
                        if (start_i[i]) begin
                            state_d[i] = StWaitGnt;
                            addr_d[i]  = boot_addr_i[i];
                        end
                    end
                    StWaitGnt: begin
                        if (gnt[i]) begin
                            state_d[i] = StRst;
                            cnt_d[i]   = CntW'(RstCycles);
                        end
                    end
                    StRst: begin
                        if (cnt_q[i] == CntW'(1)) begin
                            state_d[i] = StSettle;
                            cnt_d[i]   = CntW'(SettleCycles);
                        end else begin
                            cnt_d[i] = cnt_q[i] - CntW'(1);
                        end
                    end
                    StSettle: begin
                        if (cnt_q[i] == CntW'(1)) begin
                            state_d[i] = StRun;
`ifdef CARFIELD_BOOT_TIMEOUT_EN
                            tcnt_d[i]  = '0;
`endif
                        end else begin
                            cnt_d[i] = cnt_q[i] - CntW'(1);
                        end
                    end
                    StRun: begin
                        if (eoc_i[i]) begin
                            state_d[i] = StDone;
                            done_d[i]  = 1'b1;
                        end
`ifdef CARFIELD_BOOT_TIMEOUT_EN
                        else if (tcnt_q[i] == TW'(TimeoutCycles - 1)) begin
                            state_d[i] = StErr;
                        end else begin
                            tcnt_d[i] = tcnt_q[i] + TW'(1);
                        end
`endif
                    end
                    default: state_d[i] = StOff;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumIslands; i++) begin
                state_q[i] <= StOff;
                cnt_q[i]   <= '0;
`ifdef CARFIELD_BOOT_TIMEOUT_EN
                tcnt_q[i]  <= '0;
`endif
            end
            addr_q      <= {NumIslands{DefaultBootAddr}};
            done_q      <= '0;
            slot_held_q <= 1'b0;
            holder_q    <= '0;
            rr_q        <= '0;
        end else begin
            for (int i = 0; i < NumIslands; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef CARFIELD_BOOT_TIMEOUT_EN
                tcnt_q[i]  <= tcnt_d[i];
`endif
            end
            addr_q      <= addr_d;
            done_q      <= done_d;
            slot_held_q <= slot_held_d;
            holder_q    <= holder_d;
            rr_q        <= rr_d;
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        for (int i = 0; i < NumIslands; i++) begin
            isl_rst_o[i]      = state_q[i] inside {StOff, StWaitGnt, StRst, StErr};
            isl_clk_en_o[i]   = state_q[i] inside {StRst, StSettle, StRun, StDone};
            isl_fetch_en_o[i] = (state_q[i] == StRun);
`ifdef CARFIELD_BOOT_TIMEOUT_EN
            err_o[i]          = (state_q[i] == StErr);
`else
            err_o[i]          = 1'b0;
`endif
        end
    end

    assign isl_boot_addr_o = addr_q;
    assign done_irq_o      = done_q;
    assign busy_o          = slot_held_q;

endmodule

// File: tb/tb_carfield_island_boot_seq.sv
// Directed bench for carfield_island_boot_seq. Inputs change and outputs are
// sampled 1 time unit after the rising edge. "Cycle n" below means n rising
// edges after the stimulus cycle 0.
module tb_carfield_island_boot_seq;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [1:0]        start_i, stop_i, eoc_i;
    logic [1:0][31:0]  boot_addr_i;
    logic [1:0]        isl_rst_o, isl_clk_en_o, isl_fetch_en_o, done_irq_o, err_o;
    logic [1:0][31:0]  isl_boot_addr_o;
    logic              busy_o;

    int checks   = 0;
    int failures = 0;

    carfield_island_boot_seq #(
        .NumIslands     (2),
        .AddrWidth      (32),
        .RstCycles      (16),
        .SettleCycles   (4),
        .TimeoutCycles  (8),
        .DefaultBootAddr(32'h7800_0000)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .boot_addr_i    (boot_addr_i),
        .eoc_i          (eoc_i),
        .isl_rst_o      (isl_rst_o),
        .isl_clk_en_o   (isl_clk_en_o),
        .isl_fetch_en_o (isl_fetch_en_o),
        .isl_boot_addr_o(isl_boot_addr_o),
        .done_irq_o     (done_irq_o),
        .err_o          (err_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1; start_i = '0; stop_i = '0; eoc_i = '0;
        boot_addr_i = '0;
        tick(2);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (isl_rst_o !== 2'b11) begin failures++;
            $display("FAIL reset_rst got=%b exp=11", isl_rst_o); end
        checks++; if (isl_clk_en_o !== 2'b00) begin failures++;
            $display("FAIL reset_clk_en got=%b exp=00", isl_clk_en_o); end
        checks++; if (isl_fetch_en_o !== 2'b00 || done_irq_o !== 2'b00 || err_o !== 2'b00) begin
            failures++; $display("FAIL reset_fetch_done_err got=%b/%b/%b exp=00/00/00",
                                 isl_fetch_en_o, done_irq_o, err_o); end
        checks++; if (busy_o !== 1'b0) begin failures++;
            $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (isl_boot_addr_o[0] !== 32'h7800_0000 || isl_boot_addr_o[1] !== 32'h7800_0000)
        begin failures++; $display("FAIL reset_addr got=%h/%h exp=78000000",
                                   isl_boot_addr_o[0], isl_boot_addr_o[1]); end
    endtask

    // Both islands request in cycle 0; island f is expected first, o second.
    task automatic test_pair(input int f);
        int o;
        o = 1 - f;
        start_i = 2'b11; boot_addr_i[0] = 32'h1000_0000; boot_addr_i[1] = 32'h2000_0000;
        tick(1); start_i = '0;
        tick(1); // cycle 2
        checks++; if (isl_clk_en_o[f] !== 1'b1 || isl_clk_en_o[o] !== 1'b0) begin failures++;
            $display("FAIL pair%0d_first_grant got=%b exp first=%0d", f, isl_clk_en_o, f); end
        tick(19); // cycle 21
        checks++; if (isl_fetch_en_o[f] !== 1'b0 || isl_clk_en_o[o] !== 1'b0) begin failures++;
            $display("FAIL pair%0d_c21 got fetch=%b clk_en=%b", f, isl_fetch_en_o, isl_clk_en_o); end
        tick(1); // cycle 22: f in RUN, o already in RST
        checks++; if (isl_fetch_en_o[f] !== 1'b1 || isl_clk_en_o[o] !== 1'b1 ||
                      isl_rst_o[o] !== 1'b1 || busy_o !== 1'b1) begin failures++;
            $display("FAIL pair%0d_c22 got fetch=%b clk_en=%b rst=%b busy=%b", f,
                     isl_fetch_en_o, isl_clk_en_o, isl_rst_o, busy_o); end
        tick(19); // cycle 41
        checks++; if (isl_fetch_en_o[o] !== 1'b0) begin failures++;
            $display("FAIL pair%0d_second_early got=%b exp=0", f, isl_fetch_en_o[o]); end
        tick(1); // cycle 42
        checks++; if (isl_fetch_en_o[o] !== 1'b1 || busy_o !== 1'b0) begin failures++;
            $display("FAIL pair%0d_second_run got fetch=%b busy=%b exp 1/0", f,
                     isl_fetch_en_o[o], busy_o); end
    endtask

    task automatic test_single_boot();
        do_reset();
        start_i = 2'b01; boot_addr_i[0] = 32'h6000_0000;
        tick(1); start_i = '0; boot_addr_i[0] = 32'hdead_beef;
        checks++; if (isl_rst_o[0] !== 1'b1 || isl_clk_en_o[0] !== 1'b0) begin failures++;
            $display("FAIL boot_wait got rst=%b clk_en=%b exp 1/0", isl_rst_o[0], isl_clk_en_o[0]); end
        tick(1); // cycle 2
        checks++; if (isl_rst_o[0] !== 1'b1 || isl_clk_en_o[0] !== 1'b1 || busy_o !== 1'b1) begin
            failures++; $display("FAIL boot_rst got rst=%b clk_en=%b busy=%b exp 1/1/1",
                                 isl_rst_o[0], isl_clk_en_o[0], busy_o); end
        tick(15); // cycle 17
        checks++; if (isl_rst_o[0] !== 1'b1) begin failures++;
            $display("FAIL boot_rst_c17 got=%b exp=1", isl_rst_o[0]); end
        tick(1); // cycle 18
        checks++; if (isl_rst_o[0] !== 1'b0 || isl_fetch_en_o[0] !== 1'b0) begin failures++;
            $display("FAIL boot_rst_c18 got rst=%b fetch=%b exp 0/0", isl_rst_o[0],
                     isl_fetch_en_o[0]); end
        tick(3); // cycle 21
        checks++; if (isl_fetch_en_o[0] !== 1'b0) begin failures++;
            $display("FAIL boot_fetch_c21 got=%b exp=0", isl_fetch_en_o[0]); end
        tick(1); // cycle 22
        checks++; if (isl_fetch_en_o[0] !== 1'b1 || busy_o !== 1'b0) begin failures++;
            $display("FAIL boot_fetch_c22 got fetch=%b busy=%b exp 1/0", isl_fetch_en_o[0], busy_o); end
        checks++; if (isl_boot_addr_o[0] !== 32'h6000_0000) begin failures++;
            $display("FAIL boot_addr got=%h exp=60000000", isl_boot_addr_o[0]); end
    endtask

    task automatic test_eoc();
        checks++; if (done_irq_o !== 2'b00) begin failures++;
            $display("FAIL eoc_pre_irq got=%b exp=00", done_irq_o); end
        eoc_i = 2'b01;
        tick(1); eoc_i = '0;
        checks++; if (isl_fetch_en_o[0] !== 1'b0 || done_irq_o[0] !== 1'b1 ||
                      isl_clk_en_o[0] !== 1'b1) begin failures++;
            $display("FAIL eoc_done got fetch=%b irq=%b clk_en=%b exp 0/1/1",
                     isl_fetch_en_o[0], done_irq_o[0], isl_clk_en_o[0]); end
        tick(1);
        checks++; if (done_irq_o[0] !== 1'b0 || isl_clk_en_o[0] !== 1'b1) begin failures++;
            $display("FAIL eoc_pulse_len got irq=%b clk_en=%b exp 0/1", done_irq_o[0],
                     isl_clk_en_o[0]); end
    endtask

    // Island 1 holds the slot, island 0 waits; island 1 stopped at RST count 5.
    task automatic test_stop();
        do_reset();
        start_i = 2'b10; boot_addr_i[1] = 32'h3000_0000;
        tick(1); start_i = '0;
        tick(2); // cycle 3
        start_i = 2'b01; boot_addr_i[0] = 32'h4000_0000;
        tick(1); start_i = '0;
        tick(9); // cycle 13, island 1 RST count 5
        checks++; if (isl_clk_en_o !== 2'b10 || busy_o !== 1'b1) begin failures++;
            $display("FAIL stop_pre got clk_en=%b busy=%b exp 10/1", isl_clk_en_o, busy_o); end
        stop_i = 2'b10;
        tick(1); stop_i = '0; // cycle 14
        checks++; if (isl_rst_o[1] !== 1'b1 || isl_clk_en_o[1] !== 1'b0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL stop_off got rst=%b clk_en=%b busy=%b exp 1/0/0",
                                 isl_rst_o[1], isl_clk_en_o[1], busy_o); end
        tick(1); // cycle 15
        checks++; if (isl_clk_en_o[0] !== 1'b1 || isl_rst_o[0] !== 1'b1 || busy_o !== 1'b1) begin
            failures++; $display("FAIL stop_regrant got clk_en=%b rst=%b busy=%b exp 1/1/1",
                                 isl_clk_en_o[0], isl_rst_o[0], busy_o); end
        tick(20); // cycle 35
        checks++; if (isl_fetch_en_o[0] !== 1'b1) begin failures++;
            $display("FAIL stop_pending_run got=%b exp=1", isl_fetch_en_o[0]); end
    endtask

    // Continues from test_stop: island 0 entered RUN at cycle 35.
    task automatic test_timeout();
        tick(7); // cycle 42, eighth RUN cycle
        checks++; if (isl_fetch_en_o[0] !== 1'b1 || err_o[0] !== 1'b0) begin failures++;
            $display("FAIL tmo_c42 got fetch=%b err=%b exp 1/0", isl_fetch_en_o[0], err_o[0]); end
        tick(1); // cycle 43
`ifdef CARFIELD_BOOT_TIMEOUT_EN
        checks++; if (err_o[0] !== 1'b1 || isl_rst_o[0] !== 1'b1 || isl_clk_en_o[0] !== 1'b0) begin
            failures++; $display("FAIL tmo_err got err=%b rst=%b clk_en=%b exp 1/1/0",
                                 err_o[0], isl_rst_o[0], isl_clk_en_o[0]); end
        tick(3);
        checks++; if (err_o[0] !== 1'b1) begin failures++;
            $display("FAIL tmo_sticky got=%b exp=1", err_o[0]); end
        start_i = 2'b01;
        tick(1); start_i = '0;
        checks++; if (err_o[0] !== 1'b0) begin failures++;
            $display("FAIL tmo_clear got=%b exp=0", err_o[0]); end
`else
        checks++; if (err_o[0] !== 1'b0 || isl_fetch_en_o[0] !== 1'b1) begin failures++;
            $display("FAIL notmo_c43 got err=%b fetch=%b exp 0/1", err_o[0], isl_fetch_en_o[0]); end
        tick(40);
        checks++; if (err_o[0] !== 1'b0 || isl_fetch_en_o[0] !== 1'b1) begin failures++;
            $display("FAIL notmo_late got err=%b fetch=%b exp 0/1", err_o[0], isl_fetch_en_o[0]); end
`endif
    endtask

    task automatic test_rst_mid();
        do_reset();
        start_i = 2'b01; boot_addr_i[0] = 32'h1234_5678;
        tick(1); start_i = '0;
        tick(18); // cycle 19, SETTLE
        checks++; if (isl_rst_o[0] !== 1'b0 || isl_clk_en_o[0] !== 1'b1) begin failures++;
            $display("FAIL rstmid_settle got rst=%b clk_en=%b exp 0/1", isl_rst_o[0],
                     isl_clk_en_o[0]); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (isl_rst_o !== 2'b11 || isl_clk_en_o !== 2'b00 || busy_o !== 1'b0) begin
            failures++; $display("FAIL rstmid_outputs got rst=%b clk_en=%b busy=%b exp 11/00/0",
                                 isl_rst_o, isl_clk_en_o, busy_o); end
        checks++; if (isl_boot_addr_o[0] !== 32'h7800_0000) begin failures++;
            $display("FAIL rstmid_addr got=%h exp=78000000", isl_boot_addr_o[0]); end
        tick(2);
        rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pair(0);
        test_single_boot();
        test_eoc();
        test_pair(1); // pointer sits at 1 after island 0's solo grant
        test_stop();
        test_timeout();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
